// File: rtl/conv_fetch_pkg.sv
// Shared types and defaults for the conv operand fetch stage.
package conv_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_MEM_LAT    = 2;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
    localparam int unsigned MEM_LAT_MAX        = 4;

endpackage

// File: rtl/conv_operand_fetch_if.sv
// Bundle of address, SRAM and PE-side signals around the operand fetch stage.
// Optional macro: FETCH_ALIGN_CHECK_EN adds the sticky addr_err flag.
interface conv_operand_fetch_if
    import conv_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
    logic                  addr_valid;
    logic [ADDR_WIDTH-1:0] addr_ifm;
    logic [ADDR_WIDTH-1:0] addr_filter;
    logic                  addr_ready;
    logic                  done_compute;

    logic                  mem_ifm_rd_en;
    logic [ADDR_WIDTH-3:0] mem_ifm_addr;
    logic [DATA_WIDTH-1:0] mem_ifm_rdata;
    logic                  mem_flt_rd_en;
    logic [ADDR_WIDTH-3:0] mem_flt_addr;
    logic [DATA_WIDTH-1:0] mem_flt_rdata;

    logic                  pe_valid;
    logic [DATA_WIDTH-1:0] pe_ifm_data;
    logic [DATA_WIDTH-1:0] pe_flt_data;
    logic                  pe_ready;

    logic                  busy;
    logic                  flush_done;
`ifdef FETCH_ALIGN_CHECK_EN
    logic                  addr_err;
`endif

    // Surroundings: address generator, SRAMs and PE array
    modport master (
        output addr_valid, addr_ifm, addr_filter, done_compute,
        input  addr_ready,
        input  mem_ifm_rd_en, mem_ifm_addr, mem_flt_rd_en, mem_flt_addr,
        output mem_ifm_rdata, mem_flt_rdata,
        input  pe_valid, pe_ifm_data, pe_flt_data,
        output pe_ready,
        input  busy, flush_done
`ifdef FETCH_ALIGN_CHECK_EN
        , input addr_err
`endif
    );

    // The fetch stage itself
    modport slave (
        input  addr_valid, addr_ifm, addr_filter, done_compute,
        output addr_ready,
        output mem_ifm_rd_en, mem_ifm_addr, mem_flt_rd_en, mem_flt_addr,
        input  mem_ifm_rdata, mem_flt_rdata,
        output pe_valid, pe_ifm_data, pe_flt_data,
        input  pe_ready,
        output busy, flush_done
`ifdef FETCH_ALIGN_CHECK_EN
        , output addr_err
`endif
    );

endinterface

// File: rtl/operand_fifo.sv
// Synchronous operand FIFO; head read straight from the storage registers.
module operand_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_count
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_pop;

    assign w_do_pop = i_pop && (r_count != '0);

    // Storage, pointers and occupancy; push is never refused because the
    // upstream credit check guarantees a free slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem    <= '{default: '0};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_do_pop);
        end
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/conv_operand_fetch.sv
// Operand fetch stage: issues paired IFM/filter word reads under credit
// control, realigns fixed-latency returns and buffers them for the PE array.
// Optional macro: FETCH_ALIGN_CHECK_EN enables the sticky addr_err flag.
module conv_operand_fetch
    import conv_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned MEM_LAT    = DEFAULT_MEM_LAT,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input logic                 clk,
    input logic                 rst_n,
    conv_operand_fetch_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic [CNT_W-1:0]      r_inflight;
    logic [CNT_W-1:0]      w_fifo_count;
    logic [CNT_W-1:0]      w_credit_used;
    logic [MEM_LAT-1:0]    r_ret_sr;
    logic                  w_addr_ready;
    logic                  w_acc;
    logic                  w_ret;
    logic                  w_pop;
    logic                  w_fifo_valid;
    logic                  w_flush;
    logic [2*DATA_WIDTH-1:0] w_head;

    // Reads in flight plus buffered pairs never exceed the FIFO size.
    assign w_credit_used = r_inflight + w_fifo_count;
    assign w_addr_ready  = (r_state != StDrain) && (w_credit_used < CNT_W'(FIFO_DEPTH));
    assign w_acc         = bus.addr_valid && w_addr_ready;
    assign w_ret         = r_ret_sr[MEM_LAT-1];
    assign w_pop         = w_fifo_valid && bus.pe_ready;

    assign bus.addr_ready    = w_addr_ready;
    assign bus.mem_ifm_rd_en = w_acc;
    assign bus.mem_flt_rd_en = w_acc;
    assign bus.mem_ifm_addr  = bus.addr_ifm[ADDR_WIDTH-1:2];
    assign bus.mem_flt_addr  = bus.addr_filter[ADDR_WIDTH-1:2];

    if (MEM_LAT == 1) begin : g_lat1
        // Return tracker: data arrives the cycle after the read strobe
        always_ff @(posedge clk) begin
            if (!rst_n) r_ret_sr <= '0;
            else        r_ret_sr <= w_acc;
        end
    end else begin : g_latn
        // Return tracker: one stage per cycle of SRAM latency
        always_ff @(posedge clk) begin
            if (!rst_n) r_ret_sr <= '0;
            else        r_ret_sr <= {r_ret_sr[MEM_LAT-2:0], w_acc};
        end
    end

    // Outstanding read counter and FSM state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= '0;
            r_state    <= StIdle;
        end else begin
            r_inflight <= r_inflight + CNT_W'(w_acc) - CNT_W'(w_ret);
            r_state    <= w_state_next;
        end
    end

    // Next-state logic; drain completes once nothing is in flight or buffered
    always_comb begin
        w_state_next = r_state;
        w_flush      = 1'b0;
        unique case (r_state)
            StIdle:  if (w_acc) w_state_next = StRun;
            StRun:   if (bus.done_compute) w_state_next = StDrain;
            StDrain: begin
                if ((r_inflight == '0) && !w_fifo_valid) begin
                    w_state_next = StIdle;
                    w_flush      = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    operand_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_ret),
        .i_data  ({bus.mem_ifm_rdata, bus.mem_flt_rdata}),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_head),
        .o_count (w_fifo_count)
    );

    assign bus.pe_valid    = w_fifo_valid;
    assign bus.pe_ifm_data = w_head[2*DATA_WIDTH-1:DATA_WIDTH];
    assign bus.pe_flt_data = w_head[DATA_WIDTH-1:0];
    assign bus.busy        = (r_state != StIdle);
    assign bus.flush_done  = w_flush;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_addr_err;

    // Sticky misalignment flag; the read itself still goes out truncated
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr_err <= 1'b0;
        end else if (w_acc && ((|bus.addr_ifm[1:0]) || (|bus.addr_filter[1:0]))) begin
            r_addr_err <= 1'b1;
        end
    end

    assign bus.addr_err = r_addr_err;
`else
    // Byte-offset bits are intentionally dropped
    logic w_unused_lsbs;
    assign w_unused_lsbs = ^{bus.addr_ifm[1:0], bus.addr_filter[1:0]};
`endif

endmodule
